// File: rtl/cmos_timing_pkg.sv
// Shared types and defaults for the CMOS sensor timing generator.
// Holds the sequencer state enum, the default timing constants and the
// helper that derives the 4-byte-aligned row stride of the pixel image.
package cmos_timing_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  localparam int DEF_H_DISP    = 640;
  localparam int DEF_V_DISP    = 480;
  localparam int DEF_H_SYNC    = 5;
  localparam int DEF_H_BACK    = 5;
  localparam int DEF_H_FRONT   = 5;
  localparam int DEF_V_SYNC    = 1;
  localparam int DEF_V_BACK    = 0;
  localparam int DEF_V_FRONT   = 1;
  localparam int DEF_BYTES_PP  = 3;
  localparam int DEF_HDR_BYTES = 54;

  // Image rows are padded so that each row starts on a 4-byte boundary.
  function automatic int calc_stride(input int h_disp, input int bytes_pp);
    return ((h_disp * bytes_pp + 3) / 4) * 4;
  endfunction

endpackage

// File: rtl/cmos_addr_gen.sv
// Pixel memory address generator.
// Turns the active-area coordinates into the byte address of the pixel's
// first byte, registered together with the read strobe.
// Ports: clk/rst_n; i_x, i_y active coordinates; i_ahead active-area flag;
//        o_rd_en read strobe (i_ahead delayed one cycle); o_rd_addr address.
module cmos_addr_gen
  import cmos_timing_pkg::*;
#(
  parameter int H_DISP    = DEF_H_DISP,
  parameter int V_DISP    = DEF_V_DISP,
  parameter int BYTES_PP  = DEF_BYTES_PP,
  parameter int HDR_BYTES = DEF_HDR_BYTES,
  parameter int FLIP_V    = 1,
  parameter int ADDR_W    = 21,
  parameter int CNT_W     = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CNT_W-1:0]  i_x,
  input  logic [CNT_W-1:0]  i_y,
  input  logic              i_ahead,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr
);

  localparam int STRIDE = calc_stride(H_DISP, BYTES_PP);

  logic [ADDR_W-1:0] w_row;
  logic [ADDR_W-1:0] w_addr;
  logic              r_rd_en;
  logic [ADDR_W-1:0] r_rd_addr;

  // Bottom-up images store the last display row first.
  assign w_row  = (FLIP_V != 0) ? (ADDR_W'(V_DISP - 1) - ADDR_W'(i_y)) : ADDR_W'(i_y);
  assign w_addr = ADDR_W'(HDR_BYTES) + w_row * ADDR_W'(STRIDE)
                + ADDR_W'(i_x) * ADDR_W'(BYTES_PP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_en   <= 1'b0;
      r_rd_addr <= '0;
    end else begin
      r_rd_en <= i_ahead;
      if (i_ahead) r_rd_addr <= w_addr;
    end
  end

  assign o_rd_en   = r_rd_en;
  assign o_rd_addr = r_rd_addr;

endmodule

// File: rtl/cmos_timing_gen.sv
// CMOS sensor style timing generator.
// Produces vsync/href/clken framing for a raster of H_TOTAL x V_TOTAL
// cycles, pixel coordinates aligned with href, and a pixel memory read
// (rd_en/rd_addr) one cycle ahead of href.
// Ports: clk, rst_n (async, active-low); en run enable; mode 0=continuous,
//        1=single-shot; start single-shot trigger; vsync, href, clken,
//        x_out, y_out video outputs; rd_en, rd_addr memory read;
//        frame_done end-of-frame pulse; frame_cnt completed frames; busy.
//
// state     | meaning
// ST_IDLE   | counters held at 0, waiting for en (and start in single-shot)
// ST_RUN    | scanning frames
// ST_FINISH | en dropped mid-frame; completing the frame before idling
module cmos_timing_gen
  import cmos_timing_pkg::*;
#(
  parameter int   H_DISP    = DEF_H_DISP,
  parameter int   V_DISP    = DEF_V_DISP,
  parameter int   H_SYNC    = DEF_H_SYNC,
  parameter int   H_BACK    = DEF_H_BACK,
  parameter int   H_FRONT   = DEF_H_FRONT,
  parameter int   V_SYNC    = DEF_V_SYNC,
  parameter int   V_BACK    = DEF_V_BACK,
  parameter int   V_FRONT   = DEF_V_FRONT,
  parameter int   BYTES_PP  = DEF_BYTES_PP,
  parameter int   HDR_BYTES = DEF_HDR_BYTES,
  parameter int   FLIP_V    = 1,
  parameter logic VS_ACTIVE = 1'b0,
  parameter int   ADDR_W    = 21,
  parameter int   CNT_W     = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              mode,
  input  logic              start,
  output logic              vsync,
  output logic              href,
  output logic              clken,
  output logic [CNT_W-1:0]  x_out,
  output logic [CNT_W-1:0]  y_out,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              frame_done,
  output logic [15:0]       frame_cnt,
  output logic              busy
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_START = CNT_W'(H_SYNC + H_BACK);
  localparam logic [CNT_W-1:0] H_END   = CNT_W'(H_SYNC + H_BACK + H_DISP);
  localparam logic [CNT_W-1:0] V_START = CNT_W'(V_SYNC + V_BACK);
  localparam logic [CNT_W-1:0] V_END   = CNT_W'(V_SYNC + V_BACK + V_DISP);
  localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_SYNC);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_hcnt, r_vcnt;
  logic             w_running, w_line_end, w_frame_end, w_ahead;
  logic [CNT_W-1:0] w_x, w_y;
  logic             r_ahead_d1;
  logic [CNT_W-1:0] r_x_d1, r_y_d1;
  logic             r_vsync, r_href, r_frame_done;
  logic [CNT_W-1:0] r_x_out, r_y_out;
  logic [15:0]      r_frame_cnt;

  assign w_running   = (r_state != ST_IDLE);
  assign w_line_end  = (r_hcnt == H_LAST);
  assign w_frame_end = w_line_end && (r_vcnt == V_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // A frame is never cut short: dropping en only moves RUN to FINISH.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (en && (!mode || start)) w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (w_frame_end && (mode || !en)) w_state_nxt = ST_IDLE;
        else if (!en)                     w_state_nxt = ST_FINISH;
      end
      ST_FINISH: if (w_frame_end) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else if (!w_running) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else if (w_line_end) begin
      r_hcnt <= '0;
      r_vcnt <= (r_vcnt == V_LAST) ? '0 : r_vcnt + 1'b1;
    end else begin
      r_hcnt <= r_hcnt + 1'b1;
    end
  end

  assign w_ahead = w_running && (r_vcnt >= V_START) && (r_vcnt < V_END)
                && (r_hcnt >= H_START) && (r_hcnt < H_END);
  assign w_x = r_hcnt - H_START;
  assign w_y = r_vcnt - V_START;

  // Stage 1 feeds the address generator's timing; stage 2 is the video output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ahead_d1   <= 1'b0;
      r_x_d1       <= '0;
      r_y_d1       <= '0;
      r_href       <= 1'b0;
      r_x_out      <= '0;
      r_y_out      <= '0;
      r_vsync      <= VS_ACTIVE;
      r_frame_done <= 1'b0;
      r_frame_cnt  <= '0;
    end else begin
      r_ahead_d1   <= w_ahead;
      r_x_d1       <= w_x;
      r_y_d1       <= w_y;
      r_href       <= r_ahead_d1;
      r_x_out      <= r_x_d1;
      r_y_out      <= r_y_d1;
      r_vsync      <= (w_running && (r_vcnt >= V_SYNC_END)) ? ~VS_ACTIVE : VS_ACTIVE;
      r_frame_done <= w_running && w_frame_end;
      if (w_running && w_frame_end) r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  cmos_addr_gen #(
    .H_DISP    (H_DISP),
    .V_DISP    (V_DISP),
    .BYTES_PP  (BYTES_PP),
    .HDR_BYTES (HDR_BYTES),
    .FLIP_V    (FLIP_V),
    .ADDR_W    (ADDR_W),
    .CNT_W     (CNT_W)
  ) u_addr_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_x       (w_x),
    .i_y       (w_y),
    .i_ahead   (w_ahead),
    .o_rd_en   (rd_en),
    .o_rd_addr (rd_addr)
  );

  assign vsync      = r_vsync;
  assign href       = r_href;
  assign clken      = r_href;
  assign x_out      = r_x_out;
  assign y_out      = r_y_out;
  assign frame_done = r_frame_done;
  assign frame_cnt  = r_frame_cnt;
  assign busy       = w_running;

endmodule
